// File: rtl/stepmotor_pkg.sv
// Shared definitions for the stepper phase decoder: coil phase codes, drive-mode codes,
// tracker states and the phase-pattern to wheel-index map.
package stepmotor_pkg;

    localparam logic [3:0] PH_A     = 4'b0001;
    localparam logic [3:0] PH_A_BAR = 4'b0010;
    localparam logic [3:0] PH_B     = 4'b0100;
    localparam logic [3:0] PH_B_BAR = 4'b1000;

    localparam logic [1:0] MODE_NONE   = 2'b00;
    localparam logic [1:0] MODE_ONE    = 2'b01;
    localparam logic [1:0] MODE_TWO    = 2'b10;
    localparam logic [1:0] MODE_ONETWO = 2'b11;

    localparam logic [0:0] S_NOREF = 1'b0;
    localparam logic [0:0] S_TRACK = 1'b1;

    typedef struct packed {
        logic       valid;
        logic       idle;
        logic [2:0] idx;
    } wheel_t;

    // Position of a pattern on the 8-entry half-step wheel; idle and illegal flagged.
    function automatic wheel_t wheel_decode(input logic [3:0] pat);
        wheel_t w;
        w.valid = 1'b1;
        w.idle  = 1'b0;
        w.idx   = 3'd0;
        case (pat)
            PH_A:                w.idx = 3'd0;
            PH_A | PH_B:         w.idx = 3'd1;
            PH_B:                w.idx = 3'd2;
            PH_B | PH_A_BAR:     w.idx = 3'd3;
            PH_A_BAR:            w.idx = 3'd4;
            PH_A_BAR | PH_B_BAR: w.idx = 3'd5;
            PH_B_BAR:            w.idx = 3'd6;
            PH_B_BAR | PH_A:     w.idx = 3'd7;
            4'b0000: begin
                w.valid = 1'b0;
                w.idle  = 1'b1;
            end
            default:             w.valid = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/phase_filter.sv
// Two-flop synchronizer followed by a stability filter: a pattern is accepted once it has
// been steady for FILT_LEN cycles and differs from the last accepted one.
module phase_filter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] pattern,
    output logic             accept
);

    localparam int unsigned CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] FULL = CW'(FILT_LEN);

    logic [WIDTH-1:0] sync1, sync2, cand;
    logic [CW-1:0]    cnt, cnt_next;
    logic             take;

    always_comb begin
        if (sync2 != cand) begin
            cnt_next = CW'(1);
        end else if (cnt == FULL) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CW'(1);
        end
        take = (cnt_next == FULL) && (sync2 != pattern);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            cand    <= '0;
            cnt     <= '0;
            pattern <= '0;
            accept  <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            cand   <= sync2;
            cnt    <= cnt_next;
            accept <= take;
            if (take) begin
                pattern <= sync2;
            end
        end
    end

endmodule

// File: rtl/stepmotor_phase_decoder.sv
// Decodes the monitored coil-phase bus into position, direction, drive mode, step period,
// motion status and sticky error flags.
module stepmotor_phase_decoder
    import stepmotor_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned PER_W    = 24,
    parameter int unsigned TIMEOUT  = 2000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              step_phase,
    input  logic                    err_clr,
    output logic signed [CNT_W-1:0] pos_count,
    output logic                    step_pulse,
    output logic                    dir,
    output logic [1:0]              mode,
    output logic [PER_W-1:0]        step_period,
    output logic                    moving,
    output logic                    illegal_err,
    output logic                    skip_err
);

    localparam int unsigned IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

    logic [3:0]       acc_pat;
    logic             accept;
    wheel_t           wh;
    logic [0:0]       state, state_next;
    logic [2:0]       ref_idx, ref_next, delta;
    logic             count, fwd, two, ill_set, skip_set;
    logic [CNT_W-1:0] step_amt;
    logic [1:0]       mode_next;
    logic [PER_W-1:0] per_cnt;
    logic [IW-1:0]    idle_cnt;
    logic             seen;

    phase_filter #(
        .WIDTH    (4),
        .FILT_LEN (FILT_LEN)
    ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .raw     (step_phase),
        .pattern (acc_pat),
        .accept  (accept)
    );

    assign wh    = wheel_decode(acc_pat);
    assign delta = wh.idx - ref_idx;

    always_comb begin
        state_next = state;
        ref_next   = ref_idx;
        count      = 1'b0;
        fwd        = 1'b0;
        two        = 1'b0;
        ill_set    = 1'b0;
        skip_set   = 1'b0;
        if (accept) begin
            if (wh.idle) begin
                state_next = S_NOREF;
            end else if (!wh.valid) begin
                ill_set    = 1'b1;
                state_next = S_NOREF;
            end else begin
                state_next = S_TRACK;
                ref_next   = wh.idx;
                // From S_NOREF a valid pattern only establishes the reference.
                if (state == S_TRACK) begin
                    case (delta)
                        3'd1: begin
                            count = 1'b1;
                            fwd   = 1'b1;
                        end
                        3'd2: begin
                            count = 1'b1;
                            fwd   = 1'b1;
                            two   = 1'b1;
                        end
                        3'd7: count = 1'b1;
                        3'd6: begin
                            count = 1'b1;
                            two   = 1'b1;
                        end
                        3'd3, 3'd4, 3'd5: skip_set = 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign step_amt  = two ? CNT_W'(2) : CNT_W'(1);
    assign mode_next = !two ? MODE_ONETWO : ($onehot(acc_pat) ? MODE_ONE : MODE_TWO);
    assign moving    = seen && (idle_cnt < IDLE_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_NOREF;
            ref_idx     <= 3'd0;
            pos_count   <= '0;
            step_pulse  <= 1'b0;
            dir         <= 1'b0;
            mode        <= MODE_NONE;
            step_period <= '0;
            per_cnt     <= '0;
            idle_cnt    <= '0;
            seen        <= 1'b0;
            illegal_err <= 1'b0;
            skip_err    <= 1'b0;
        end else begin
            state      <= state_next;
            ref_idx    <= ref_next;
            step_pulse <= count;
            if (count) begin
                pos_count   <= fwd ? pos_count + step_amt : pos_count - step_amt;
                dir         <= fwd;
                mode        <= mode_next;
                step_period <= per_cnt;
                per_cnt     <= PER_W'(1);
                idle_cnt    <= '0;
                seen        <= 1'b1;
            end else begin
                if (per_cnt != '1) begin
                    per_cnt <= per_cnt + PER_W'(1);
                end
                if (idle_cnt != IDLE_MAX) begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end
            // A new error outranks a simultaneous clear.
            illegal_err <= ill_set | (illegal_err & ~err_clr);
            skip_err    <= skip_set | (skip_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_stepmotor_phase_decoder.sv
// Scoreboard bench: stimulus pushes expected step results from a wheel-arithmetic model,
// a negedge monitor pops them on every step_pulse; state is also compared after long holds.
module tb_stepmotor_phase_decoder;

    localparam int unsigned FILT_LEN = 4;
    localparam int unsigned TIMEOUT  = 200;
    localparam int LAT = 2 + FILT_LEN + 1;

    localparam logic [3:0] PAT [8] = '{4'b0001, 4'b0101, 4'b0100, 4'b0110,
                                       4'b0010, 4'b1010, 4'b1000, 4'b1001};
    localparam logic [3:0] ILL [7] = '{4'b0011, 4'b0111, 4'b1011, 4'b1100,
                                       4'b1101, 4'b1110, 4'b1111};

    logic               clk;
    logic               reset;
    logic [3:0]         step_phase;
    logic               err_clr;
    logic signed [31:0] pos_count;
    logic               step_pulse;
    logic               dir;
    logic [1:0]         mode;
    logic [23:0]        step_period;
    logic               moving;
    logic               illegal_err;
    logic               skip_err;

    stepmotor_phase_decoder #(
        .FILT_LEN (FILT_LEN),
        .CNT_W    (32),
        .PER_W    (24),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .step_phase  (step_phase),
        .err_clr     (err_clr),
        .pos_count   (pos_count),
        .step_pulse  (step_pulse),
        .dir         (dir),
        .mode        (mode),
        .step_period (step_period),
        .moving      (moving),
        .illegal_err (illegal_err),
        .skip_err    (skip_err)
    );

    typedef struct {
        logic signed [31:0] pos;
        logic               dir;
        logic [1:0]         mode;
        longint             period;
        bit                 per_ok;
    } exp_t;

    exp_t   q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc = 0;

    // Reference model state
    logic [3:0]         m_acc;
    bit                 m_ref;
    int                 m_idx;
    logic signed [31:0] m_pos;
    logic               m_dir;
    logic [1:0]         m_mode;
    logic               m_ill, m_skip;
    bit                 m_seen, m_per_ok;
    longint             m_last_t;
    logic [3:0]         lastp;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic int wheel_of(input logic [3:0] p);
        if (p == 4'b0000) return -2;
        for (int i = 0; i < 8; i++) begin
            if (PAT[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_acc = 4'b0000; m_ref = 0; m_idx = 0; m_pos = 0; m_dir = 0; m_mode = 2'b00;
        m_ill = 0; m_skip = 0; m_seen = 0; m_per_ok = 0; m_last_t = 0; lastp = 4'b0000;
        q.delete();
    endtask

    task automatic model_accept(input logic [3:0] p, input longint t);
        int   w;
        int   d;
        int   s;
        exp_t e;
        w = wheel_of(p);
        m_acc = p;
        if (w == -1) begin
            m_ill = 1; m_ref = 0;
        end else if (w == -2) begin
            m_ref = 0;
        end else if (!m_ref) begin
            m_ref = 1; m_idx = w; m_per_ok = 0;
        end else begin
            d = (w - m_idx + 8) % 8;
            m_idx = w;
            if (d >= 3 && d <= 5) begin
                m_skip = 1;
            end else begin
                s = (d <= 2) ? d : d - 8;
                m_pos = m_pos + s;
                m_dir = (s > 0);
                m_mode = (d % 2 == 1) ? 2'b11 : (($countones(p) == 1) ? 2'b01 : 2'b10);
                e.pos = m_pos; e.dir = m_dir; e.mode = m_mode;
                e.period = t - m_last_t; e.per_ok = m_per_ok;
                q.push_back(e);
                m_last_t = t; m_per_ok = 1; m_seen = 1;
            end
        end
    endtask

    task automatic check_state(input string tag);
        longint e;
        chk({tag, " pos_count"}, pos_count, m_pos);
        chk({tag, " dir"}, dir, m_dir);
        chk({tag, " mode"}, mode, m_mode);
        chk({tag, " illegal_err"}, illegal_err, m_ill);
        chk({tag, " skip_err"}, skip_err, m_skip);
        if (!m_seen) begin
            chk({tag, " moving"}, moving, 0);
        end else begin
            e = cyc - m_last_t - LAT;
            if (e < TIMEOUT - 2) chk({tag, " moving"}, moving, 1);
            else if (e > TIMEOUT + 2) chk({tag, " moving"}, moving, 0);
        end
    endtask

    // Apply pattern p for h cycles; err_clr pulses after edge c of the hold (c < 0: none).
    task automatic seg(input logic [3:0] p, input int h, input int c);
        longint t;
        bit     acc;
        t = cyc;
        acc = (h >= FILT_LEN) && (p != m_acc);
        step_phase = p;
        if (c == LAT - 1) begin
            m_ill = 0; m_skip = 0;
        end
        if (acc) model_accept(p, t);
        if (c >= LAT) begin
            m_ill = 0; m_skip = 0;
        end
        for (int i = 1; i <= h; i++) begin
            @(posedge clk);
            #1;
            err_clr = (i == c);
        end
        err_clr = 1'b0;
        lastp = p;
        if (h >= LAT + 1) check_state("seg");
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        m_ill = 0; m_skip = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " pos_count"}, pos_count, 0);
        chk({tag, " step_pulse"}, step_pulse, 0);
        chk({tag, " dir"}, dir, 0);
        chk({tag, " mode"}, mode, 0);
        chk({tag, " step_period"}, step_period, 0);
        chk({tag, " moving"}, moving, 0);
        chk({tag, " illegal_err"}, illegal_err, 0);
        chk({tag, " skip_err"}, skip_err, 0);
    endtask

    always @(negedge clk) begin
        if (!reset && step_pulse) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected step_pulse: actual 1, required 0 (pos %0d)", pos_count);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse pos_count", pos_count, e.pos);
                chk("pulse dir", dir, e.dir);
                chk("pulse mode", mode, e.mode);
                if (e.per_ok) chk("pulse step_period", step_period, e.period);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] p;
        int r, base, d, h, c;
        reset = 1'b1; step_phase = 4'b0000; err_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all_zero("reset");

        // Single-phase forward
        seg(4'b0001, 50, -1); seg(4'b0100, 50, -1); seg(4'b0010, 50, -1);
        seg(4'b1000, 50, -1); seg(4'b0001, 50, -1);
        chk("one-phase pos_count", pos_count, 8);
        chk("one-phase mode", mode, 2'b01);
        chk("one-phase dir", dir, 1);

        // Two-phase reverse
        seg(4'b0000, 20, -1);
        seg(4'b1001, 50, -1); seg(4'b1010, 50, -1); seg(4'b0110, 50, -1);
        seg(4'b0101, 50, -1); seg(4'b1001, 50, -1);
        chk("two-phase pos_count", pos_count, 0);
        chk("two-phase mode", mode, 2'b10);
        chk("two-phase dir", dir, 0);

        // Half-step forward, then timeout
        seg(4'b0000, 20, -1);
        seg(4'b0001, 40, -1); seg(4'b0101, 40, -1); seg(4'b0100, 40, -1);
        seg(4'b0110, TIMEOUT + 20, -1);
        chk("half-step pos_count", pos_count, 3);
        chk("half-step mode", mode, 2'b11);
        chk("timeout moving", moving, 0);

        // Glitch shorter than the filter, then a skip and a clear
        seg(4'b0000, 20, -1); seg(4'b0001, 40, -1);
        seg(4'b0100, FILT_LEN - 1, -1); seg(4'b0001, 40, -1);
        chk("glitch pos_count", pos_count, 3);
        seg(4'b0010, 40, -1);
        chk("skip skip_err", skip_err, 1);
        pulse_clr();
        chk("err_clr skip_err", skip_err, 0);

        // Illegal pattern, re-reference, then +2
        seg(4'b0011, 40, -1);
        chk("illegal illegal_err", illegal_err, 1);
        seg(4'b0100, 40, -1);
        chk("re-reference pos_count", pos_count, 3);
        seg(4'b0010, 40, -1);
        chk("after re-reference pos_count", pos_count, 5);

        // Reset mid-pattern
        step_phase = 4'b0101;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("mid reset");
        chk("mid reset queue", q.size(), 0);
        step_phase = 4'b0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // err_clr coincident with a skip event
        seg(4'b0001, 40, -1);
        seg(4'b0010, 40, LAT - 1);
        chk("coincident skip_err", skip_err, 1);
        pulse_clr();

        // Random walk with skips, idles, illegal codes and glitches
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            base = m_ref ? m_idx : int'($urandom_range(0, 7));
            if (r < 60) begin
                case ($urandom_range(0, 3))
                    0: d = 1;
                    1: d = 2;
                    2: d = 6;
                    default: d = 7;
                endcase
                p = PAT[(base + d) % 8];
            end else if (r < 70) begin
                p = PAT[(base + 3 + int'($urandom_range(0, 2))) % 8];
            end else if (r < 78) begin
                p = 4'b0000;
            end else if (r < 86) begin
                p = ILL[$urandom_range(0, 6)];
            end else begin
                p = PAT[$urandom_range(0, 7)];
            end
            if (p == lastp) p = (lastp == 4'b0000) ? 4'b0001 : 4'b0000;
            h = ($urandom_range(0, 99) < 15) ? int'($urandom_range(1, 6))
                                             : int'($urandom_range(8, 60));
            c = -1;
            if (h >= 12 && $urandom_range(0, 9) == 0) c = int'($urandom_range(LAT, h - 1));
            seg(p, h, c);
        end

        seg(4'b0000, 20, -1);
        chk("pulse queue drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
